controller_response_rx: RTL

//  Receive side of the single-wire controller link. The poll transmitter sends
//  the poll command and then releases the line; this block decodes the

---
 rtl/controller_response_rx.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/controller_response_rx.sv
// Receive side of the single-wire controller link: decodes a pulse-width coded
// reply frame into a word with a valid strobe, or raises an error strobe.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for arm from the poll transmitter
// S_WAIT_ST  | armed, waiting for the first falling edge of the reply
// S_LOW      | timing a low phase (data bit or stop bit)
// S_HIGH     | timing the high phase between bits
// S_DONE     | frame accepted, valid strobe cycle
// S_ERR      | frame aborted, error strobe cycle
module controller_response_rx #(
   parameter int NUM_BITS    = 64,
   parameter int THRESH      = 200,
   parameter int MIN_LOW     = 25,
   parameter int BIT_TIMEOUT = 500,
   parameter int ARM_TIMEOUT = 20000
) (
   input  logic                PCLK,
   input  logic                PRESERN,
   input  logic                arm,
   input  logic                line_in,
   output logic [NUM_BITS-1:0] resp_data,
   output logic                resp_valid,
   output logic                resp_err,
   output logic                busy
);

   localparam int CW = $clog2(ARM_TIMEOUT + 1);
   localparam int BW = $clog2(NUM_BITS + 1);

   localparam logic [CW-1:0] C_THRESH  = CW'(THRESH);
   localparam logic [CW-1:0] C_MIN_LOW = CW'(MIN_LOW);
   localparam logic [CW-1:0] C_BIT_TO  = CW'(BIT_TIMEOUT);
   localparam logic [CW-1:0] C_ARM_TO  = CW'(ARM_TIMEOUT);
   localparam logic [BW-1:0] C_NBITS   = BW'(NUM_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ST,
      S_LOW,
      S_HIGH,
      S_DONE,
      S_ERR
   } state_t;

   state_t              r_state;
   logic                r_sync1;
   logic                r_line_s;
   logic                r_line_d;
   logic [CW-1:0]       r_cnt;
   logic [NUM_BITS-1:0] r_sh;
   logic [BW-1:0]       r_bit_cnt;
   logic [NUM_BITS-1:0] r_data;
   logic                r_valid;
   logic                r_err;

   logic                w_rise;
   logic                w_fall;
   logic [CW-1:0]       w_len;
   logic                w_short;

   assign w_rise  = r_line_s & ~r_line_d;
   assign w_fall  = ~r_line_s & r_line_d;
   // The counter clears on the cycle after the falling edge is seen, so the
   // low phase length at the rising edge is one more than the count.
   assign w_len   = r_cnt + CW'(1);
   assign w_short = (w_len < C_THRESH);

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         r_sync1  <= 1'b1;
         r_line_s <= 1'b1;
         r_line_d <= 1'b1;
      end else begin
         r_sync1  <= line_in;
         r_line_s <= r_sync1;
         r_line_d <= r_line_s;
      end
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_sh      <= '0;
         r_bit_cnt <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_rise || w_fall) begin
            r_cnt <= '0;
         end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (arm) begin
                  r_state   <= S_WAIT_ST;
                  r_cnt     <= '0;
                  r_sh      <= '0;
                  r_bit_cnt <= '0;
               end
            end
            S_WAIT_ST: begin
               if (w_fall) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt >= C_ARM_TO) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_LOW: begin
               if (w_rise) begin
                  r_cnt <= '0;
                  if (w_len < C_MIN_LOW) begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end else if (r_bit_cnt < C_NBITS) begin
                     r_sh      <= {r_sh[NUM_BITS-2:0], w_short};
                     r_bit_cnt <= r_bit_cnt + BW'(1);
                     r_state   <= S_HIGH;
                  end else if (w_short) begin
                     r_state <= S_DONE;
                     r_data  <= r_sh;
                     r_valid <= 1'b1;
                  end else begin
                     r_state <= S_ERR;
                     r_err   <= 1'b1;
                  end
               end else if (r_cnt >= C_BIT_TO) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_HIGH: begin
               if (w_fall) begin
                  r_state <= S_LOW;
                  r_cnt   <= '0;
               end else if (r_cnt >= C_BIT_TO) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            S_DONE, S_ERR: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign resp_data  = r_data;
   assign resp_valid = r_valid;
   assign resp_err   = r_err;
   assign busy       = (r_state != S_IDLE);

endmodule
